// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a combinational program ROM and
// holds one fetched instruction for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int INST_W   = 16,
  parameter int RESET_PC = 0,
  parameter bit WRAP_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              halted
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              last;

  // A redirect always wins over a load, so the flushed slot is never refilled
  // with the instruction at the stale PC.
  assign load     = (state == RUN) && (!inst_valid || inst_ready) && !redirect_valid;
  assign last     = (pc == {ADDR_W{1'b1}});
  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (load && last && !WRAP_EN) state_nxt = DONE;
      DONE:    if (redirect_valid) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    halted = (state == DONE);
  end

  // PC and output buffer; PC+1 wraps naturally at the top of the address space.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= ADDR_W'(RESET_PC);
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else if (redirect_valid) begin
      pc         <= redirect_pc;
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_data  <= rom_data;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
      pc         <= pc + ADDR_W'(1);
    end else if (inst_ready) begin
      inst_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: wrapping and halting variants share stimulus; each is
// checked every cycle against its own behavioural model, plus directed checks.
module tb_fetch_unit;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, redirect_valid, inst_ready;
  logic [3:0]  redirect_pc;
  logic [3:0]  rom_addr_w, rom_addr_s, inst_pc_w, inst_pc_s;
  logic [15:0] rom_data_w, rom_data_s, inst_data_w, inst_data_s;
  logic        inst_valid_w, inst_valid_s, halted_w, halted_s;
  logic [15:0] rom [16];

  int n_checks = 0;
  int n_errors = 0;

  int m_pc[2], m_st[2], m_v[2], m_d[2], m_p[2];
  int seen_pc[$], seen_data[$];

  always #5 clk = ~clk;

  assign rom_data_w = rom[rom_addr_w];
  assign rom_data_s = rom[rom_addr_s];

  fetch_unit #(.ADDR_W(4), .INST_W(16), .RESET_PC(0), .WRAP_EN(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid_w),
    .inst_data(inst_data_w), .inst_pc(inst_pc_w), .inst_ready(inst_ready), .halted(halted_w));

  fetch_unit #(.ADDR_W(4), .INST_W(16), .RESET_PC(0), .WRAP_EN(1'b0)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr_s), .rom_data(rom_data_s),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid_s),
    .inst_data(inst_data_s), .inst_pc(inst_pc_s), .inst_ready(inst_ready), .halted(halted_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Next-cycle behaviour from the inputs applied before the coming edge; k=1 halts at end of ROM.
  task automatic model_step(input int k);
    bit ld;
    if (!rst_n) begin
      m_pc[k] = 0; m_st[k] = ST_IDLE; m_v[k] = 0; m_d[k] = 0; m_p[k] = 0;
      return;
    end
    ld = (m_st[k] == ST_RUN) && (m_v[k] == 0 || inst_ready);
    if (redirect_valid) begin
      m_pc[k] = int'(redirect_pc);
      m_v[k]  = 0;
      if (m_st[k] == ST_DONE || (m_st[k] == ST_IDLE && start)) m_st[k] = ST_RUN;
    end else if (ld) begin
      m_d[k] = int'(rom[m_pc[k]]);
      m_p[k] = m_pc[k];
      m_v[k] = 1;
      if (m_pc[k] == 15 && k == 1) m_st[k] = ST_DONE;
      m_pc[k] = (m_pc[k] + 1) % 16;
    end else begin
      if (m_v[k] == 1 && inst_ready) m_v[k] = 0;
      if (m_st[k] == ST_IDLE && start) m_st[k] = ST_RUN;
    end
  endtask

  task automatic check_all();
    chk("w_valid", 32'(inst_valid_w), 32'(m_v[0]));
    chk("w_addr",  32'(rom_addr_w),   32'(m_pc[0]));
    chk("w_halt",  32'(halted_w),     32'(m_st[0] == ST_DONE));
    if (m_v[0] == 1) begin
      chk("w_data", 32'(inst_data_w), 32'(m_d[0]));
      chk("w_pc",   32'(inst_pc_w),   32'(m_p[0]));
    end
    chk("s_valid", 32'(inst_valid_s), 32'(m_v[1]));
    chk("s_addr",  32'(rom_addr_s),   32'(m_pc[1]));
    chk("s_halt",  32'(halted_s),     32'(m_st[1] == ST_DONE));
    if (m_v[1] == 1) begin
      chk("s_data", 32'(inst_data_s), 32'(m_d[1]));
      chk("s_pc",   32'(inst_pc_s),   32'(m_p[1]));
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [15:0] exp_seq [4];
    exp_seq = '{16'h1202, 16'hF200, 16'h0200, 16'h1405};
    for (int i = 0; i < 16; i++) rom[i] = 16'h3000 + 16'(i * 16'h0111);
    rom[0] = 16'h1202; rom[1] = 16'hF200; rom[2]  = 16'h0200; rom[3]  = 16'h1405;
    rom[4] = 16'hF400; rom[9] = 16'h1A0B; rom[12] = 16'h1E0E; rom[15] = 16'h0200;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_st[k] = 0; m_v[k] = 0; m_d[k] = 0; m_p[k] = 0;
    end

    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_valid", 32'(inst_valid_w), 0);
    chk("rst_data",  32'(inst_data_w), 0);

    // Straight-line fetch at one instruction per cycle.
    rst_n = 1'b1; start = 1'b1; inst_ready = 1'b1;
    repeat (5) begin
      tick();
      if (inst_valid_w) begin
        seen_pc.push_back(int'(inst_pc_w));
        seen_data.push_back(int'(inst_data_w));
      end
    end
    chk("seq_len", 32'(seen_pc.size()), 4);
    for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
      chk("seq_pc",   32'(seen_pc[i]),   32'(i));
      chk("seq_data", 32'(seen_data[i]), 32'(exp_seq[i]));
    end

    // Backpressure holds the buffer and the PC.
    start = 1'b0; inst_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_data", 32'(inst_data_w), 32'h1405);
      chk("stall_addr", 32'(rom_addr_w), 4);
    end
    inst_ready = 1'b1;
    tick();
    chk("resume_pc",   32'(inst_pc_w), 4);
    chk("resume_data", 32'(inst_data_w), 32'hF400);

    // Redirect flushes a stalled instruction.
    inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 4'd12;
    tick();
    chk("redir_flush", 32'(inst_valid_w), 0);
    chk("redir_addr",  32'(rom_addr_w), 12);
    redirect_valid = 1'b0;
    tick();
    chk("redir_data", 32'(inst_data_w), 32'h1E0E);
    chk("redir_pc",   32'(inst_pc_w), 12);

    // Run the halting variant into DONE, then resume via redirect to 9.
    inst_ready = 1'b1;
    repeat (6) tick();
    chk("done_halt", 32'(halted_s), 1);
    chk("done_addr", 32'(rom_addr_s), 0);
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    tick();
    chk("resume_halt", 32'(halted_s), 0);
    redirect_valid = 1'b0;
    tick();
    chk("done_redir_data", 32'(inst_data_s), 32'h1A0B);
    chk("done_redir_pc",   32'(inst_pc_s), 9);

    // Randomised traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      start          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = 4'($urandom_range(0, 15));
      inst_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
